// File: rtl/sm3_pkg.sv
// Shared widths, FSM encoding and the length-insertion helper for the SM3 padding stage.
package sm3_pkg;

  localparam int SM3_BLOCK_W = 512;
  localparam int LEN_W       = 64;
  localparam int BYTES_W     = 7;

  localparam logic [SM3_BLOCK_W-1:0] PAD80_BLOCK = {8'h80, {(SM3_BLOCK_W-8){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    EMIT_EXTRA
  } pad_state_t;

  // Bytes 56..63 (big-endian) are the low 64 bits of the block.
  function automatic logic [SM3_BLOCK_W-1:0] insert_len(
    input logic [SM3_BLOCK_W-1:0] blk,
    input logic [LEN_W-1:0]       len
  );
    logic [SM3_BLOCK_W-1:0] r;
    r = blk;
    r[LEN_W-1:0] = len;
    return r;
  endfunction

endpackage

// File: rtl/sm3_pad_mask.sv
// Keeps bytes 0..n-1 of a block, writes 0x80 at byte n (when n<64) and zeros the rest.
module sm3_pad_mask
  import sm3_pkg::*;
(
  input  logic [SM3_BLOCK_W-1:0] block,
  input  logic [BYTES_W-1:0]     n,
  output logic [SM3_BLOCK_W-1:0] masked
);

  always_comb begin
    masked = '0;
    for (int i = 0; i < SM3_BLOCK_W / 8; i++) begin
      if (BYTES_W'(i) < n) begin
        masked[SM3_BLOCK_W-1-8*i -: 8] = block[SM3_BLOCK_W-1-8*i -: 8];
      end else if (BYTES_W'(i) == n) begin
        masked[SM3_BLOCK_W-1-8*i -: 8] = 8'h80;
      end
    end
  end

endmodule

// File: rtl/sm3_msg_pad.sv
// SM3 message padding stage: tracks message bit length and emits one or two padded
// 512-bit blocks per input block to the compression core.
module sm3_msg_pad
  import sm3_pkg::*;
(
  input  logic                   io_mainClk,
  input  logic                   resetCtrl_systemReset,
  input  logic                   io_in_valid,
  output logic                   io_in_ready,
  input  logic [SM3_BLOCK_W-1:0] io_in_block,
  input  logic [BYTES_W-1:0]     io_in_bytes,
  input  logic                   io_in_first,
  input  logic                   io_in_last,
  output logic                   io_out_valid,
  input  logic                   io_out_ready,
  output logic [SM3_BLOCK_W-1:0] io_out_block,
  output logic                   io_out_first,
  output logic                   io_out_last,
  output logic                   io_err
);

  // Handshakes: a transfer happens on a rising edge where valid && ready. A source
  // holding valid keeps its payload stable until the transfer; valid never waits on ready.

  pad_state_t             state_q, state_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic                   msg_active_q, msg_active_d;
  logic                   err_q, err_d;
  logic                   out_valid_q, out_valid_d;
  logic [SM3_BLOCK_W-1:0] out_block_q, out_block_d;
  logic                   out_first_q, out_first_d;
  logic                   out_last_q, out_last_d;
  logic                   extra_q, extra_d;
  logic                   pad80_q, pad80_d;

  logic [SM3_BLOCK_W-1:0] masked;
  logic                   accept;
  logic                   bad;
  logic [LEN_W-1:0]       len_sum;

  sm3_pad_mask u_mask (
    .block  (io_in_block),
    .n      (io_in_bytes),
    .masked (masked)
  );

  assign io_in_ready  = (state_q == IDLE);
  assign io_out_valid = out_valid_q;
  assign io_out_block = out_block_q;
  assign io_out_first = out_first_q;
  assign io_out_last  = out_last_q;
  assign io_err       = err_q;

  assign accept  = io_in_valid && io_in_ready;
  assign bad     = (io_in_bytes > 7'd64) ||
                   (!io_in_last && (io_in_bytes != 7'd64)) ||
                   (!io_in_first && !msg_active_q);
  assign len_sum = (io_in_first ? '0 : len_q) + {54'b0, io_in_bytes, 3'b000};

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    msg_active_d = msg_active_q;
    err_d        = err_q;
    out_valid_d  = out_valid_q;
    out_block_d  = out_block_q;
    out_first_d  = out_first_q;
    out_last_d   = out_last_q;
    extra_d      = extra_q;
    pad80_d      = pad80_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bad) begin
            err_d = 1'b1;
          end else begin
            if (io_in_first) err_d = 1'b0;
            len_d        = len_sum;
            msg_active_d = !io_in_last;
            state_d      = EMIT;
            out_valid_d  = 1'b1;
            out_first_d  = io_in_first;
            out_block_d  = masked;
            out_last_d   = 1'b0;
            extra_d      = 1'b0;
            pad80_d      = 1'b0;
            if (io_in_last) begin
              // Length fits behind the data only when at most 55 data bytes are present.
              if (io_in_bytes <= 7'd55) begin
                out_block_d = insert_len(masked, len_sum);
                out_last_d  = 1'b1;
              end else begin
                extra_d = 1'b1;
                pad80_d = (io_in_bytes == 7'd64);
              end
            end
          end
        end
      end
      EMIT: begin
        if (io_out_ready) begin
          if (extra_q) begin
            state_d     = EMIT_EXTRA;
            out_block_d = insert_len(pad80_q ? PAD80_BLOCK : '0, len_q);
            out_first_d = 1'b0;
            out_last_d  = 1'b1;
            extra_d     = 1'b0;
          end else begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end
        end
      end
      EMIT_EXTRA: begin
        if (io_out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge io_mainClk) begin
    if (resetCtrl_systemReset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      msg_active_q <= 1'b0;
      err_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_block_q  <= '0;
      out_first_q  <= 1'b0;
      out_last_q   <= 1'b0;
      extra_q      <= 1'b0;
      pad80_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      msg_active_q <= msg_active_d;
      err_q        <= err_d;
      out_valid_q  <= out_valid_d;
      out_block_q  <= out_block_d;
      out_first_q  <= out_first_d;
      out_last_q   <= out_last_d;
      extra_q      <= extra_d;
      pad80_q      <= pad80_d;
    end
  end

endmodule

// File: tb/tb_sm3_msg_pad.sv
// Directed and randomized bench for sm3_msg_pad against a byte-level padding model.
module tb_sm3_msg_pad;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_block;
  logic [6:0]   in_bytes;
  logic         in_first;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_block;
  logic         out_first;
  logic         out_last;
  logic         err;

  int checks   = 0;
  int failures = 0;

  // Expected outputs: {first, last, block}.
  logic [513:0] exp_q[$];
  logic [7:0]   msg[$];

  sm3_msg_pad dut (
    .io_mainClk            (clk),
    .resetCtrl_systemReset (rst),
    .io_in_valid           (in_valid),
    .io_in_ready           (in_ready),
    .io_in_block           (in_block),
    .io_in_bytes           (in_bytes),
    .io_in_first           (in_first),
    .io_in_last            (in_last),
    .io_out_valid          (out_valid),
    .io_out_ready          (out_ready),
    .io_out_block          (out_block),
    .io_out_first          (out_first),
    .io_out_last           (out_last),
    .io_err                (err)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Padding model: msg || 0x80 || zeros until length = 56 mod 64 || 64-bit bit length.
  task automatic model_expect();
    logic [7:0]   p[$];
    logic [63:0]  bits;
    logic [511:0] b;
    int           nb;
    p = msg;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    bits = 64'(msg.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
    nb = p.size() / 64;
    for (int i = 0; i < nb; i++) begin
      b = '0;
      for (int j = 0; j < 64; j++) b[511-8*j -: 8] = p[64*i + j];
      exp_q.push_back({(i == 0), (i == nb - 1), b});
    end
  endtask

  // Slice of msg starting at off, with random garbage past the valid bytes.
  function automatic logic [511:0] make_blk(input int off, input int n);
    logic [511:0] b;
    for (int j = 0; j < 64; j++) begin
      if (j < n) b[511-8*j -: 8] = msg[off + j];
      else       b[511-8*j -: 8] = 8'($urandom);
    end
    return b;
  endfunction

  // ---------------- driver tasks (enter and leave on a negedge) ----------------
  task automatic drive(input logic [511:0] blk, input int n, input logic f, input logic l);
    chk("in_ready_before_send", 512'(in_ready), 512'(1));
    in_valid = 1'b1;
    in_block = blk;
    in_bytes = 7'(n);
    in_first = f;
    in_last  = l;
    @(negedge clk);
    in_valid = 1'b0;
    in_block = '0;
    in_bytes = '0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input int n, input int stall);
    logic [513:0] e;
    for (int s = 0; s < stall; s++) begin
      if (exp_q.size() == 0) break;
      e = exp_q[0];
      chk("stall_valid", 512'(out_valid), 512'(1));
      chk("stall_block", out_block, e[511:0]);
      chk("stall_first", 512'(out_first), 512'(e[513]));
      chk("stall_last", 512'(out_last), 512'(e[512]));
      chk("stall_in_ready", 512'(in_ready), 512'(0));
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (exp_q.size() == 0) break;
      e = exp_q.pop_front();
      chk("out_valid", 512'(out_valid), 512'(1));
      chk("out_block", out_block, e[511:0]);
      chk("out_first", 512'(out_first), 512'(e[513]));
      chk("out_last", 512'(out_last), 512'(e[512]));
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("valid_after_drain", 512'(out_valid), 512'(0));
    chk("in_ready_after_drain", 512'(in_ready), 512'(1));
  endtask

  // Sends the whole of msg as input blocks and checks every output block.
  task automatic send_msg(input int stall);
    int L, nblk, n;
    L    = msg.size();
    nblk = (L == 0) ? 1 : (L + 63) / 64;
    model_expect();
    for (int b = 0; b < nblk; b++) begin
      n = (b == nblk - 1) ? (L - 64*b) : 64;
      drive(make_blk(64*b, n), n, (b == 0), (b == nblk - 1));
      chk("err_clear", 512'(err), 512'(0));
      drain((b == nblk - 1) ? exp_q.size() : 1, (b == 0) ? stall : 0);
    end
  endtask

  task automatic check_error_case(input string tag, input logic [511:0] blk, input int n,
                                  input logic f, input logic l);
    drive(blk, n, f, l);
    chk({tag, "_err"}, 512'(err), 512'(1));
    chk({tag, "_no_valid"}, 512'(out_valid), 512'(0));
    chk({tag, "_idle"}, 512'(in_ready), 512'(1));
    @(negedge clk);
    chk({tag, "_still_no_valid"}, 512'(out_valid), 512'(0));
    chk({tag, "_err_sticky"}, 512'(err), 512'(1));
    // A good first block clears the error.
    msg.delete();
    for (int i = 0; i < 5; i++) msg.push_back(8'($urandom));
    send_msg(0);
  endtask

  // ---------------- stimulus ----------------
  logic [511:0] abc_exp;
  logic [511:0] blk;
  int           len;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_block  = '0;
    in_bytes  = '0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_in_ready", 512'(in_ready), 512'(1));
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    chk("rst_out_block", out_block, 512'(0));
    chk("rst_out_first", 512'(out_first), 512'(0));
    chk("rst_out_last", 512'(out_last), 512'(0));
    chk("rst_err", 512'(err), 512'(0));

    // "abc": one block, also checked against a literal.
    abc_exp = {32'h61626380, 416'h0, 64'h18};
    msg = '{8'h61, 8'h62, 8'h63};
    model_expect();
    drive(make_blk(0, 3), 3, 1'b1, 1'b1);
    chk("abc_literal", out_block, abc_exp);
    drain(exp_q.size(), 0);

    // 64 bytes "abcd" x16: data block then 0x80 + length 0x200.
    msg.delete();
    for (int i = 0; i < 64; i++) msg.push_back(8'h61 + 8'(i % 4));
    send_msg(0);

    // 56 bytes: 0x80 at byte 56, length in a second block.
    msg.delete();
    for (int i = 0; i < 56; i++) msg.push_back(8'($urandom));
    send_msg(0);

    // 55 bytes: last length that fits in one block.
    msg.delete();
    for (int i = 0; i < 55; i++) msg.push_back(8'($urandom));
    send_msg(0);

    // Empty message.
    msg.delete();
    send_msg(0);

    // Multi-block: 64 + 3 bytes, length 0x218.
    msg.delete();
    for (int i = 0; i < 67; i++) msg.push_back(8'($urandom));
    send_msg(0);

    // Backpressure: ready held low for 5 cycles on the first output.
    msg.delete();
    for (int i = 0; i < 10; i++) msg.push_back(8'($urandom));
    send_msg(5);

    // Reset while a block is being emitted drops it.
    msg.delete();
    for (int i = 0; i < 64; i++) msg.push_back(8'($urandom));
    drive(make_blk(0, 64), 64, 1'b1, 1'b0);
    chk("pre_reset_valid", 512'(out_valid), 512'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("reset_in_emit_valid", 512'(out_valid), 512'(0));
    chk("reset_in_emit_ready", 512'(in_ready), 512'(1));
    exp_q.delete();

    // Protocol errors, each followed by a clearing first block.
    for (int i = 0; i < 64; i++) blk[511-8*i -: 8] = 8'($urandom);
    check_error_case("err_short_not_last", blk, 10, 1'b1, 1'b0);
    check_error_case("err_n65", blk, 65, 1'b1, 1'b1);
    check_error_case("err_no_first", blk, 3, 1'b0, 1'b1);

    // Randomized messages of assorted lengths and stalls.
    for (int t = 0; t < 24; t++) begin
      len = $urandom_range(0, 200);
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      send_msg($urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
